// File: rtl/mem_interface_if.sv
// rtl/mem_interface_if.sv - datapath-side bus between the CPU MAR/MDR and the wait-state RAM
interface mem_interface_if;
    logic        MARin;
    logic [31:0] bus_in;
    logic [31:0] mdr_data;
    logic        Read;
    logic        Write;
    logic [31:0] Mdatain;
    logic        mem_rdy;
    logic        busy;
    logic        req_err;
    logic [31:0] mar_q;

    modport master (
        output MARin, bus_in, mdr_data, Read, Write,
        input  Mdatain, mem_rdy, busy, req_err, mar_q
    );

    modport slave (
        input  MARin, bus_in, mdr_data, Read, Write,
        output Mdatain, mem_rdy, busy, req_err, mar_q
    );
endinterface

// File: rtl/mem_interface.sv
// rtl/mem_interface.sv - MAR plus single-port RAM with programmable wait states
// Optional MEM_BOUNDS_CHECK_EN flags and suppresses accesses beyond 2**ADDR_BITS words.
module mem_interface #(
    parameter int ADDR_BITS   = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            clr,
    mem_interface_if.slave  bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WAIT   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
    localparam logic [3:0] WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [1:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [31:0]          mar_val_q;
    logic                 op_wr_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [31:0]          wdata_q;
    logic                 oob_q;
    logic [31:0]          rdata_q;
    logic                 err_q;
    logic                 req_ok;
    logic                 req_bad;
    logic                 req_oob;

    logic [31:0] mem [0:(2**ADDR_BITS)-1];

    assign req_ok  = bus.Read ^ bus.Write;
    assign req_bad = bus.Read & bus.Write;

`ifdef MEM_BOUNDS_CHECK_EN
    assign req_oob = |mar_val_q[31:ADDR_BITS];
`else
    assign req_oob = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_ok) begin
                    if (NO_WAIT) begin
                        state_d = ACCESS;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            mar_val_q <= 32'd0;
            op_wr_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            oob_q     <= 1'b0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (bus.MARin) begin
                mar_val_q <= bus.bus_in;
            end
            // Requests are only looked at in IDLE; strobes during an access are dropped.
            if (state_q == IDLE) begin
                if (req_bad || (req_ok && req_oob)) begin
                    err_q <= 1'b1;
                end
                if (req_ok) begin
                    op_wr_q <= bus.Write;
                    addr_q  <= mar_val_q[ADDR_BITS-1:0];
                    wdata_q <= bus.mdr_data;
                    oob_q   <= req_oob;
                end
            end
            if (state_q == ACCESS && !op_wr_q) begin
                rdata_q <= oob_q ? 32'd0 : mem[addr_q];
            end
        end
    end

    // RAM contents survive clr; clr in ACCESS still blocks the write.
    always_ff @(posedge clk) begin
        if (!clr && state_q == ACCESS && op_wr_q && !oob_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign bus.Mdatain = rdata_q;
    assign bus.mem_rdy = (state_q == DONE);
    assign bus.busy    = (state_q != IDLE);
    assign bus.req_err = err_q;
    assign bus.mar_q   = mar_val_q;
endmodule

// File: tb/tb_mem_interface.sv
// tb/tb_mem_interface.sv - directed checks for mem_interface with 2 and 0 wait states
module tb_mem_interface;
    logic clk = 1'b0;
    logic clr = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   pulses;

    mem_interface_if bus2 ();
    mem_interface_if bus0 ();

    mem_interface #(.ADDR_BITS(9), .WAIT_CYCLES(2)) u_dut2 (
        .clk (clk),
        .clr (clr),
        .bus (bus2.slave)
    );

    mem_interface #(.ADDR_BITS(9), .WAIT_CYCLES(0)) u_dut0 (
        .clk (clk),
        .clr (clr),
        .bus (bus0.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_mar2(input logic [31:0] v);
        bus2.MARin  = 1'b1;
        bus2.bus_in = v;
        tick();
        bus2.MARin  = 1'b0;
    endtask

    task automatic set_mar0(input logic [31:0] v);
        bus0.MARin  = 1'b1;
        bus0.bus_in = v;
        tick();
        bus0.MARin  = 1'b0;
    endtask

    // One access on the 2-wait instance; returns with DONE visible (mem_rdy high).
    task automatic access2(input logic wr, input logic [31:0] wd, input string tag);
        bus2.Write    = wr;
        bus2.Read     = ~wr;
        bus2.mdr_data = wd;
        tick();
        bus2.Write = 1'b0;
        bus2.Read  = 1'b0;
        tick();
        tick();
        check({tag, "_rdy_early"}, {31'd0, bus2.mem_rdy}, 32'd0);
        tick();
        check({tag, "_rdy"}, {31'd0, bus2.mem_rdy}, 32'd1);
    endtask

    initial begin
        bus2.MARin = 0; bus2.bus_in = 0; bus2.mdr_data = 0; bus2.Read = 0; bus2.Write = 0;
        bus0.MARin = 0; bus0.bus_in = 0; bus0.mdr_data = 0; bus0.Read = 0; bus0.Write = 0;
        tick();
        tick();
        clr = 1'b0;

        check("rst_mar",     bus2.mar_q, 32'd0);
        check("rst_mdatain", bus2.Mdatain, 32'd0);
        check("rst_rdy",     {31'd0, bus2.mem_rdy}, 32'd0);
        check("rst_busy",    {31'd0, bus2.busy}, 32'd0);
        check("rst_err",     {31'd0, bus2.req_err}, 32'd0);

        // Write 0x97 to 0x54: mem_rdy on the 4th edge window after the request edge
        set_mar2(32'h0000_0054);
        check("mar_load", bus2.mar_q, 32'h0000_0054);
        bus2.Write = 1'b1;
        bus2.mdr_data = 32'h0000_0097;
        tick();
        bus2.Write = 1'b0;
        check("wr_busy", {31'd0, bus2.busy}, 32'd1);
        tick();
        tick();
        check("wr_rdy_early", {31'd0, bus2.mem_rdy}, 32'd0);
        tick();
        check("wr_rdy", {31'd0, bus2.mem_rdy}, 32'd1);
        check("wr_mdatain_kept", bus2.Mdatain, 32'd0);
        tick();
        check("wr_rdy_off", {31'd0, bus2.mem_rdy}, 32'd0);
        check("wr_busy_off", {31'd0, bus2.busy}, 32'd0);

        // Read of 0x54 with Read held during the busy window: a single completion
        bus2.Read = 1'b1;
        tick();
        tick();
        tick();
        bus2.Read = 1'b0;
        tick();
        check("rd_rdy", {31'd0, bus2.mem_rdy}, 32'd1);
        check("rd_data", bus2.Mdatain, 32'h0000_0097);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus2.mem_rdy) pulses++;
        end
        check("rd_single_pulse", pulses, 32'd0);
        check("rd_no_err", {31'd0, bus2.req_err}, 32'd0);

        // MARin mid-access changes mar_q but not the address being read
        bus2.Read = 1'b1;
        tick();
        bus2.Read = 1'b0;
        bus2.MARin = 1'b1;
        bus2.bus_in = 32'h0000_0010;
        tick();
        bus2.MARin = 1'b0;
        check("mar_mid_access", bus2.mar_q, 32'h0000_0010);
        tick();
        tick();
        check("mar_mid_rdy", {31'd0, bus2.mem_rdy}, 32'd1);
        check("mar_mid_data", bus2.Mdatain, 32'h0000_0097);
        tick();

        // Seed 0x10, then abort a write of 0xDEADBEEF with clr on its first WAIT cycle
        access2(1'b1, 32'h1234_5678, "seed10");
        tick();
        bus2.Write = 1'b1;
        bus2.mdr_data = 32'hDEAD_BEEF;
        tick();
        bus2.Write = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("abort_mar",  bus2.mar_q, 32'd0);
        check("abort_data", bus2.Mdatain, 32'd0);
        check("abort_busy", {31'd0, bus2.busy}, 32'd0);
        check("abort_rdy",  {31'd0, bus2.mem_rdy}, 32'd0);
        check("abort_err",  {31'd0, bus2.req_err}, 32'd0);
        tick();
        tick();
        set_mar2(32'h0000_0010);
        access2(1'b0, 32'd0, "abort_rd");
        check("abort_ram_kept", bus2.Mdatain, 32'h1234_5678);
        tick();

        // Read and Write together: error, no access, RAM untouched
        set_mar2(32'h0000_0054);
        bus2.Read = 1'b1;
        bus2.Write = 1'b1;
        bus2.mdr_data = 32'h0000_0055;
        tick();
        bus2.Read = 1'b0;
        bus2.Write = 1'b0;
        check("both_err", {31'd0, bus2.req_err}, 32'd1);
        check("both_busy", {31'd0, bus2.busy}, 32'd0);
        tick();
        check("both_busy2", {31'd0, bus2.busy}, 32'd0);
        access2(1'b0, 32'd0, "both_rd");
        check("both_ram_kept", bus2.Mdatain, 32'h0000_0097);
        check("both_err_sticky", {31'd0, bus2.req_err}, 32'd1);
        tick();

        // Upper address bits: wrap or bounds error
        clr = 1'b1;
        tick();
        clr = 1'b0;
        set_mar2(32'h0000_0005);
        access2(1'b1, 32'h0000_0AAA, "seed05");
        tick();
        set_mar2(32'h0000_0205);
        access2(1'b1, 32'hCAFE_0001, "oob_wr");
        tick();
        access2(1'b0, 32'd0, "oob_rd");
`ifdef MEM_BOUNDS_CHECK_EN
        check("oob_rd_data", bus2.Mdatain, 32'd0);
        check("oob_err", {31'd0, bus2.req_err}, 32'd1);
`else
        check("wrap_rd_data", bus2.Mdatain, 32'hCAFE_0001);
        check("wrap_err", {31'd0, bus2.req_err}, 32'd0);
`endif
        tick();
        set_mar2(32'h0000_0005);
        access2(1'b0, 32'd0, "word5_rd");
`ifdef MEM_BOUNDS_CHECK_EN
        check("word5_data", bus2.Mdatain, 32'h0000_0AAA);
`else
        check("word5_data", bus2.Mdatain, 32'hCAFE_0001);
`endif
        tick();

        // Zero wait states: mem_rdy two edges after the request, busy for two cycles
        set_mar0(32'h0000_0007);
        bus0.Write = 1'b1;
        bus0.mdr_data = 32'h1357_9BDF;
        tick();
        bus0.Write = 1'b0;
        check("w0_busy1", {31'd0, bus0.busy}, 32'd1);
        check("w0_rdy1",  {31'd0, bus0.mem_rdy}, 32'd0);
        tick();
        check("w0_busy2", {31'd0, bus0.busy}, 32'd1);
        check("w0_rdy2",  {31'd0, bus0.mem_rdy}, 32'd1);
        tick();
        check("w0_busy3", {31'd0, bus0.busy}, 32'd0);
        // Back-to-back: request sampled right after DONE
        bus0.Read = 1'b1;
        tick();
        bus0.Read = 1'b0;
        check("r0_busy1", {31'd0, bus0.busy}, 32'd1);
        check("r0_rdy1",  {31'd0, bus0.mem_rdy}, 32'd0);
        tick();
        check("r0_rdy2",  {31'd0, bus0.mem_rdy}, 32'd1);
        check("r0_data",  bus0.Mdatain, 32'h1357_9BDF);
        tick();
        check("r0_idle",  {31'd0, bus0.busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
